// File: rtl/dmem_pipe_pkg.sv
// Shared encodings and types for the data-memory pipeline.
package dmem_pipe_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  // Request attributes held while a response is outstanding.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       err;
  } req_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane select for one access: strobes plus either write alignment or load extraction.
module dmem_lane
  import dmem_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EXTRACT = 1'b0
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   din,
  output logic [XLEN/8-1:0] strb,
  output logic [XLEN-1:0]   dout
);

  localparam int NB = XLEN / 8;

  logic [4:0]      sh;
  logic [XLEN-1:0] lane;

  assign sh = {off, 3'b000};

  // Illegal funct3 yields an empty strobe; the top treats that as an error.
  always_comb begin
    strb = '0;
    case (funct3)
      F3_B, F3_BU: strb = {{(NB-1){1'b0}}, 1'b1} << off;
      F3_H, F3_HU: strb = {{(NB-2){1'b0}}, 2'b11} << off;
      F3_W:        strb = '1;
      default:     strb = '0;
    endcase
  end

  if (EXTRACT) begin : g_rd
    assign lane = din >> sh;
    always_comb begin
      dout = '0;
      case (funct3)
        F3_B:    dout = {{(XLEN-8){lane[7]}}, lane[7:0]};
        F3_BU:   dout = {{(XLEN-8){1'b0}}, lane[7:0]};
        F3_H:    dout = {{(XLEN-16){lane[15]}}, lane[15:0]};
        F3_HU:   dout = {{(XLEN-16){1'b0}}, lane[15:0]};
        F3_W:    dout = lane;
        default: dout = '0;
      endcase
    end
  end else begin : g_wr
    assign lane = din << sh;
    assign dout = lane;
  end

endmodule

// File: rtl/dmem_pipe.sv
// Single-outstanding data memory with byte strobes, sign/zero extension and fixed read latency.
module dmem_pipe
  import dmem_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam int LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  state_t          state, state_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic            live;
  logic            accept;
  logic [AW-1:0]   idx;
  logic            oob, misalign, bad_store, req_err, wr_en;
  logic [NB-1:0]   wr_strb, rd_strb;
  logic [XLEN-1:0] wr_data, rd_ext;
  req_t            cap;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) live <= 1'b0;
    else       live <= 1'b1;

  assign req_ready = live && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];

  if (XLEN > AW + 2) begin : g_oob
    assign oob = |req_addr[XLEN-1:AW+2];
  end else begin : g_no_oob
    assign oob = 1'b0;
  end

  always_comb begin
    misalign = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misalign = req_addr[0];
      F3_W:        misalign = |req_addr[1:0];
      default:     misalign = 1'b0;
    endcase
  end

  assign bad_store = req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU);
  assign req_err   = (wr_strb == '0) || misalign || oob || bad_store;
  assign wr_en     = accept && req_we && !req_err;

  dmem_lane #(.XLEN(XLEN), .EXTRACT(1'b0)) u_wr_lane (
    .funct3 (req_funct3),
    .off    (req_addr[1:0]),
    .din    (req_wdata),
    .strb   (wr_strb),
    .dout   (wr_data)
  );

  always_ff @(posedge clk)
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (wr_strb[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];

`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (accept && req_we)
      $display("dmem_pipe: store addr=%h wdata=%h", {req_addr[XLEN-1:2], 2'b00}, req_wdata);
`endif

  // The raw word is captured pre-write; loads never write so this is the current content.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cap    <= '0;
      word_q <= '0;
    end else if (accept) begin
      cap    <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0], err: req_err};
      word_q <= mem[idx];
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (accept) begin
        state_nxt = S_BUSY;
        cnt_nxt   = '0;
      end
      S_BUSY: if (cnt == 2'(LAT_C - 1)) state_nxt = S_RESP;
              else                      cnt_nxt   = cnt + 2'd1;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  dmem_lane #(.XLEN(XLEN), .EXTRACT(1'b1)) u_rd_lane (
    .funct3 (cap.funct3),
    .off    (cap.off),
    .din    (word_q),
    .strb   (rd_strb),
    .dout   (rd_ext)
  );

  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = cap.err;
  assign rsp_rdata = (cap.we || cap.err || rd_strb == '0) ? '0 : rd_ext;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed scoreboard bench for dmem_pipe with a slow (RD_LAT=3) read path.
module tb_dmem_pipe;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  dmem_pipe #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    bit   seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rsp actual=valid required=idle (cycle %0d)", cyc);
        end else begin
          e = q[0];
          if (!seen) begin
            check("latency", 32'(cyc - e.acc), RD_LAT);
            seen = 1'b1;
          end
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          check("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
          if (rsp_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  endtask

  // Called in the posedge+#1 phase; returns one cycle after the accepting edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int   n = 0;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL req_timeout actual=not_ready required=ready addr=%h", addr);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.acc   = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
      q.delete();
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    fork monitor(); join_none

    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    //     we    f3      addr          wdata         rdata         err
    do_req(1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0);
    do_req(1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0);
    do_req(1'b1, 3'b000, 32'h13,       32'hAAAAAA7F, 32'h0,        1'b0);
    do_req(1'b0, 3'b000, 32'h13,       32'h0,        32'h0000007F, 1'b0);
    do_req(1'b0, 3'b100, 32'h12,       32'h0,        32'h000000AD, 1'b0);
    do_req(1'b0, 3'b001, 32'h10,       32'h0,        32'hFFFFBEEF, 1'b0);
    do_req(1'b0, 3'b010, 32'h12,       32'h0,        32'h0,        1'b1);
    do_req(1'b1, 3'b001, 32'h11,       32'h00005555, 32'h0,        1'b1);
    do_req(1'b0, 3'b010, 32'h10,       32'h0,        32'h7FADBEEF, 1'b0);
    do_req(1'b1, 3'b010, 32'h0,        32'hCAFEF00D, 32'h0,        1'b0);
    do_req(1'b1, 3'b010, 32'h1000,     32'h11111111, 32'h0,        1'b1);
    do_req(1'b0, 3'b010, 32'h1000,     32'h0,        32'h0,        1'b1);
    do_req(1'b0, 3'b010, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0);
    do_req(1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1);
    do_req(1'b1, 3'b100, 32'h10,       32'h0,        32'h0,        1'b1);
    do_req(1'b1, 3'b110, 32'h10,       32'h0,        32'h0,        1'b1);
    do_req(1'b0, 3'b101, 32'h12,       32'h0,        32'h00007FAD, 1'b0);
    do_req(1'b0, 3'b000, 32'h11,       32'h0,        32'hFFFFFFBE, 1'b0);
    do_req(1'b1, 3'b001, 32'h12,       32'hFFFF8001, 32'h0,        1'b0);
    do_req(1'b0, 3'b001, 32'h12,       32'h0,        32'hFFFF8001, 1'b0);
    do_req(1'b0, 3'b100, 32'h13,       32'h0,        32'h00000080, 1'b0);
    do_req(1'b0, 3'b010, 32'h10,       32'h0,        32'h8001BEEF, 1'b0);
    do_req(1'b0, 3'b101, 32'h10,       32'h0,        32'h0000BEEF, 1'b0);
    drain();

    // Back-pressure: response must hold for 5 stalled cycles.
    rsp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Reset while a load is in flight: the response is dropped, memory survives.
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
    rstn = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    q.delete();
    @(posedge clk);
    #3 rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    check("post_midrst_req_ready", {31'b0, req_ready}, 32'd1);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
    do_req(1'b0, 3'b010, 32'h0,  32'h0, 32'hCAFEF00D, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 Parameter XLEN, default 32, data and address width in bits.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of XLEN/8-byte words (power of two).
REQ-003 Parameter RD_LAT, default 1, cycles from acceptance to response, legal range 1..4.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RISC-V size/sign code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-010 req_addr  in  XLEN  byte address.
REQ-011 req_wdata  in  XLEN  store data, right-aligned.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer accepts response.
REQ-014 rsp_rdata  out  XLEN  load data, extended per funct3; 0 for stores and errors.
REQ-015 rsp_err  out  1  request was misaligned, out of range or had an illegal funct3.

Function
REQ-016 States SHALL be IDLE, BUSY, RESP; at most one request outstanding.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-018 Acceptance SHALL move IDLE->BUSY, capturing we, funct3, addr[1:0], word index and an error flag.
REQ-019 BUSY SHALL count RD_LAT-1 further cycles, then move to RESP; with RD_LAT=1, rsp_valid rises the cycle after acceptance.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready=1, then return to IDLE; no new request is accepted in that same cycle.
REQ-021 Error SHALL be flagged for: half with addr[0]=1; word with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}; addr >= DEPTH_WORDS*XLEN/8.
REQ-022 A valid store SHALL write only its byte lanes on the acceptance edge: byte lane addr[1:0], half lanes addr[1]*2+{0,1}, word all lanes; data taken from low bits of req_wdata.
REQ-023 An erroring request SHALL leave memory unmodified.
REQ-024 A valid load SHALL read the addressed word at acceptance, select the lane(s) by addr[1:0], sign-extend for 000/001, zero-extend for 100/101, word unchanged.
REQ-025 A store followed immediately by a load to the same word SHALL return the post-store data.
REQ-026 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-027 Each accepted store SHALL emit a simulation-only display of the word-aligned address and wdata.

Reset
REQ-028 rstn=0 SHALL force state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0 immediately; req_ready becomes 1 after rstn deasserts.
REQ-029 Reset mid-BUSY or mid-RESP SHALL discard the outstanding response; a store already written remains written.
REQ-030 Memory array SHALL NOT be cleared by reset; contents are undefined until written.

Structure
REQ-031 A shared package SHALL hold the funct3 encodings, the state typedef, and the RD_LAT legal range.
REQ-032 Lane-select and extend logic SHALL be one combinational sub-module, dmem_lane, instanced once for write-strobe generation and once for read extraction.
REQ-033 The array SHALL be a single register memory of DEPTH_WORDS x XLEN, one write port with byte strobes, one read port.

Verification
REQ-034 sw 0xDEADBEEF to 0x10, then lw 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, response RD_LAT cycles after acceptance.
REQ-035 After REQ-034, sb 0x7F to 0x13, lb 0x13 -> 0x0000007F; lbu 0x12 -> 0x000000AD; lh 0x10 -> 0xFFFFBEEF.
REQ-036 lw 0x12 and sh 0x11 -> rsp_err=1, rsp_rdata=0, word 0x10 unchanged on readback.
REQ-037 Hold rsp_ready=0 for 5 cycles with RD_LAT=3 -> rsp_valid and data stable for all 5 cycles, req_ready=0 throughout.
REQ-038 Assert rstn=0 during BUSY of a load -> rsp_valid drops asynchronously, no response after release, next request served normally.
REQ-039 Address 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, no write.
